// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel window controller: controller states,
// default pixel width and the counter-width helper.
package sobel_pkg;

    localparam int unsigned PIX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Width of a counter running 0..n-1. It is never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage. A read and a write share one address,
// and the read returns the old contents in the same cycle as the write.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = PIX_W_DEF
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [cnt_w(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame controller that builds 3x3 windows from a raster pixel stream and
// drives the external sobel datapath. It also aligns the results, with
// optional loop perforation.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W     = 512,
    parameter int unsigned IMG_H     = 512,
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned SOBEL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             perf_en,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] win_p0,
    output logic [PIX_W-1:0] win_p1,
    output logic [PIX_W-1:0] win_p2,
    output logic [PIX_W-1:0] win_p3,
    output logic [PIX_W-1:0] win_p5,
    output logic [PIX_W-1:0] win_p6,
    output logic [PIX_W-1:0] win_p7,
    output logic [PIX_W-1:0] win_p8,
    input  logic [7:0]       sob_out,
    output logic [7:0]       out_pix,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = cnt_w(IMG_W);
    localparam int unsigned RW = cnt_w(IMG_H);
    localparam int unsigned FW = cnt_w(SOBEL_LAT + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(SOBEL_LAT);

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [FW-1:0]    fcnt;
    logic             parity;
    logic             perf;
    logic             accept;
    logic             issue;
    logic [PIX_W-1:0] top, mid;
    logic [PIX_W-1:0] c1_top, c1_mid, c1_bot;
    logic [PIX_W-1:0] c2_top, c2_mid, c2_bot;
    logic [SOBEL_LAT:0] vld;

    assign accept = in_valid & in_ready;
    assign issue  = accept && (row >= RW'(2)) && (col >= CW'(2));

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (in_pix),
        .rdata (mid)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (mid),
        .rdata (top)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            fcnt     <= '0;
            parity   <= 1'b0;
            perf     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        col      <= '0;
                        row      <= '0;
                        parity   <= 1'b0;
                        perf     <= perf_en;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (issue) begin
                            parity <= ~parity;
                        end
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                                fcnt     <= '0;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt == FLUSH_LAST) begin
                        state <= DONE;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Column 0 of the new window is the current column 1. For that reason
    // only two columns are stored, and the third is taken straight from the
    // line buffers and the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_top    <= '0;
            c1_mid    <= '0;
            c1_bot    <= '0;
            c2_top    <= '0;
            c2_mid    <= '0;
            c2_bot    <= '0;
            win_p0    <= '0;
            win_p1    <= '0;
            win_p2    <= '0;
            win_p3    <= '0;
            win_p5    <= '0;
            win_p6    <= '0;
            win_p7    <= '0;
            win_p8    <= '0;
            vld       <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else begin
            if (accept) begin
                c1_top <= c2_top;
                c1_mid <= c2_mid;
                c1_bot <= c2_bot;
                c2_top <= top;
                c2_mid <= mid;
                c2_bot <= in_pix;
            end
            if (issue && !(perf && parity)) begin
                win_p0 <= c1_top;
                win_p1 <= c2_top;
                win_p2 <= top;
                win_p3 <= c1_mid;
                win_p5 <= mid;
                win_p6 <= c1_bot;
                win_p7 <= c2_bot;
                win_p8 <= in_pix;
            end
            vld[0] <= issue;
            for (int unsigned i = 1; i <= SOBEL_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
            out_valid <= vld[SOBEL_LAT];
            if (vld[SOBEL_LAT]) begin
                out_pix <= sob_out;
            end
        end
    end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Frame-level controller that sequences the clocked sobel datapath.
- Accepts a raster-order grayscale pixel stream, builds 3x3 windows with two line buffers, and drives the sobel input ports.
- Aligns the sobel result with a valid strobe and reports frame completion.
- Optional loop-perforation mode: every odd window reuses the previous result instead of a fresh computation.

Parameters:
- IMG_W, 512, image width in pixels (>=3)
- IMG_H, 512, image height in pixels (>=3)
- PIX_W, 8, pixel width in bits
- SOBEL_LAT, 1, clock cycles from sobel input change to a valid sobel output

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when in IDLE
- perf_en  in  1  perforation enable; sampled on the start pulse, held for the whole frame
- in_pix  in  PIX_W  input pixel, raster order
- in_valid  in  1  in_pix is valid
- in_ready  out  1  controller accepts a pixel this cycle
- win_p0..win_p3, win_p5..win_p8  out  PIX_W each  window to sobel; centre is not driven because sobel has no p4
- sob_out  in  8  sobel result
- out_pix  out  8  registered edge result
- out_valid  out  1  out_pix valid, one pulse per interior pixel
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; row, col and window-parity counters to 0.
  - All win_p*, out_pix, out_valid, done, in_ready, busy to 0.
  - Valid shift register cleared. Line-buffer contents are not cleared.
- FSM:
  - IDLE: start=1 -> RUN; clear counters; latch perf_en. in_valid is ignored in IDLE.
  - RUN: in_ready=1. Accept = in_valid & in_ready. col increments on accept and wraps at IMG_W-1; row then increments. Accept of (IMG_H-1, IMG_W-1) -> FLUSH.
  - FLUSH: in_ready=0. Wait SOBEL_LAT+1 cycles -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Window build, on accept at column c:
  - top = lb1[c], mid = lb0[c], bot = in_pix.
  - Writes: lb1[c] <= lb0[c]; lb0[c] <= in_pix. Read-before-write.
  - Column shift registers: col0 <= col1; col1 <= col2; col2 <= {top, mid, bot}.
  - With no accept, nothing shifts.
- Window issue:
  - The accepted pixel completes window k when row>=2 and col>=2.
  - Next cycle: win_p0/p1/p2 = top of col0/col1/col2; win_p3/p5 = mid of col0/col2; win_p6/p7/p8 = bot of col0/col1/col2.
  - Perforation on and k odd: win_p* hold their previous values. sob_out therefore repeats the previous result and the window still counts as one output.
  - win_p* hold between windows.
- Output alignment:
  - A valid shift register of depth SOBEL_LAT+1 carries the window strobe.
  - out_valid and out_pix <= sob_out are registered at its tail.
  - Pixel accepted at cycle t -> out_valid at t+2+SOBEL_LAT.
- Count: exactly (IMG_W-2)*(IMG_H-2) out_valid pulses per frame. The last one occurs no later than the cycle before done.
- Line-buffer use: rows 0-1 only fill the buffers. Stale contents are never consumed because issue requires row>=2.
- Reset mid-frame aborts the frame. No done pulse; the next start begins a clean frame.
- Widths: counters are $clog2(IMG_W) and $clog2(IMG_H) bits. Window parity is 1 bit, cleared at start.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W default constant
  - FSM state typedef {IDLE, RUN, FLUSH, DONE}
  - helper function for counter widths
- Sub-module sobel_line_buf: single-clock RAM of IMG_W x PIX_W, one read and one write at the same address, read-before-write. Instantiated twice.
- The sobel datapath sits outside this block; the bench and top wire it between win_p*/sob_out.

Test Plan:
1. IMG_W=4, IMG_H=4, perf_en=0, in_pix = 0..15, in_valid held -> 4 windows. First window p0..p8 (no p4) = 0,1,2,4,6,8,9,10. 4 out_valid pulses; done one cycle after FLUSH ends.
2. Same frame, perf_en=1 -> 4 out_valid pulses. Windows 1 and 3 hold win_p* from windows 0 and 2; out_pix[1]==out_pix[0] and out_pix[3]==out_pix[2].
3. Latency: note the accept cycle t of pixel (2,2) with SOBEL_LAT=1 -> first out_valid at t+3. Repeat with SOBEL_LAT=3 -> t+5.
4. Random in_valid bubbles (~50%) on the test-1 frame -> identical win_p* sequence and out_pix values to test 1. Counters advance only on accept.
5. rst_n low for 2 cycles after 7 accepts -> all outputs 0, busy=0, in_ready=0. Restart the test-1 frame -> results identical to test 1.
6. Flat 8x8 image of 100, start re-pulsed during RUN -> start ignored; 36 out_valid pulses, all out_pix=0; single done pulse.
